// File: rtl/ahbs_regif.sv
// rtl/ahbs_regif.sv - AHB slave register interface for the rotate engine
// Config regs, START/SRESET pulses, BUSY/DONE status and IRQ behind an AHB responder.

module ahbs_regif #(
    parameter int P_RD_WAIT = 0,
    parameter int P_OFS_W   = 8
) (
    input  logic        I_AHBS_HCLK,
    input  logic        I_AHBS_HRESET,
    input  logic        I_AHBS_HSEL,
    input  logic [31:0] I_AHBS_HADDR,
    input  logic [1:0]  I_AHBS_HTRANS,
    input  logic        I_AHBS_HWRITE,
    input  logic [2:0]  I_AHBS_HSIZE,
    input  logic [31:0] I_AHBS_HWDATA,
    input  logic        I_AHBS_HREADY,
    output logic [31:0] O_AHBS_HRDATA,
    output logic        O_AHBS_HREADYOUT,
    output logic [1:0]  O_AHBS_HRESP,
    input  logic        I_AHBS_BUSY,
    input  logic        I_AHBS_DONE,
    output logic        O_AHBS_START,
    output logic        O_AHBS_SRESET,
    output logic [31:0] O_AHBS_SRC_ADDR,
    output logic [31:0] O_AHBS_DST_ADDR,
    output logic [2:0]  O_AHBS_SIZE,
    output logic [4:0]  O_AHBS_COUNT,
    output logic        O_AHBS_IRQ
);

    typedef enum logic [1:0] {S_IDLE, S_RDWAIT, S_ERR1, S_ERR2} state_t;

    localparam logic [1:0]         RD_WAIT     = 2'(P_RD_WAIT);
    localparam logic [P_OFS_W-1:0] OFS_CTRL    = P_OFS_W'(32'h00);
    localparam logic [P_OFS_W-1:0] OFS_STATUS  = P_OFS_W'(32'h04);
    localparam logic [P_OFS_W-1:0] OFS_SRC     = P_OFS_W'(32'h08);
    localparam logic [P_OFS_W-1:0] OFS_DST     = P_OFS_W'(32'h0C);
    localparam logic [P_OFS_W-1:0] OFS_SIZE    = P_OFS_W'(32'h10);
    localparam logic [P_OFS_W-1:0] OFS_COUNT   = P_OFS_W'(32'h14);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         wait_cnt;
    logic [P_OFS_W-1:0] ofs;
    logic [P_OFS_W-1:0] dp_ofs;
    logic               acc;
    logic               mapped;
    logic               cfg_ofs;
    logic               err;
    logic               dp_wr;
    logic               dp_rd;
    logic               wr_en;
    logic               resp_err;
    logic               irq_en;
    logic               done;
    logic               unused;

    assign ofs    = I_AHBS_HADDR[P_OFS_W-1:0];
    assign acc    = I_AHBS_HSEL & I_AHBS_HREADY & I_AHBS_HTRANS[1];
    assign unused = ^{I_AHBS_HADDR, I_AHBS_HTRANS[0]};

    always_comb begin
        cfg_ofs = (ofs == OFS_SRC) || (ofs == OFS_DST) || (ofs == OFS_SIZE) || (ofs == OFS_COUNT);
        mapped  = cfg_ofs || (ofs == OFS_CTRL) || (ofs == OFS_STATUS);
        err     = !mapped || (I_AHBS_HSIZE != 3'b010) || (I_AHBS_HWRITE && I_AHBS_BUSY && cfg_ofs);
    end

    always_ff @(posedge I_AHBS_HCLK) begin
        if (I_AHBS_HRESET) state <= S_IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (acc) begin
            if (err)                                 state_nxt = S_ERR1;
            else if (!I_AHBS_HWRITE && RD_WAIT != 0) state_nxt = S_RDWAIT;
            else                                     state_nxt = S_IDLE;
        end else begin
            case (state)
                S_RDWAIT: if (wait_cnt == RD_WAIT) state_nxt = S_IDLE;
                S_ERR1:   state_nxt = S_ERR2;
                S_ERR2:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        O_AHBS_HREADYOUT = 1'b1;
        resp_err         = 1'b0;
        case (state)
            S_RDWAIT: O_AHBS_HREADYOUT = (wait_cnt == RD_WAIT);
            S_ERR1: begin
                O_AHBS_HREADYOUT = 1'b0;
                resp_err         = 1'b1;
            end
            S_ERR2:   resp_err = 1'b1;
            default:  O_AHBS_HREADYOUT = 1'b1;
        endcase
    end

    assign O_AHBS_HRESP = {1'b0, resp_err};

    // Data-phase context only advances while the bus is ready, so it survives wait states.
    always_ff @(posedge I_AHBS_HCLK) begin
        if (I_AHBS_HRESET) begin
            wait_cnt <= 2'd0;
            dp_wr    <= 1'b0;
            dp_rd    <= 1'b0;
            dp_ofs   <= '0;
        end else begin
            wait_cnt <= (state == S_RDWAIT && !acc) ? wait_cnt + 2'd1 : 2'd0;
            if (I_AHBS_HREADY) begin
                dp_wr  <= acc &  I_AHBS_HWRITE & ~err;
                dp_rd  <= acc & ~I_AHBS_HWRITE & ~err;
                dp_ofs <= ofs;
            end
        end
    end

    assign wr_en = dp_wr & O_AHBS_HREADYOUT;

    always_ff @(posedge I_AHBS_HCLK) begin
        if (I_AHBS_HRESET) begin
            O_AHBS_START    <= 1'b0;
            O_AHBS_SRESET   <= 1'b0;
            O_AHBS_SRC_ADDR <= '0;
            O_AHBS_DST_ADDR <= '0;
            O_AHBS_SIZE     <= '0;
            O_AHBS_COUNT    <= '0;
            O_AHBS_IRQ      <= 1'b0;
            irq_en          <= 1'b0;
            done            <= 1'b0;
        end else begin
            O_AHBS_START  <= wr_en && dp_ofs == OFS_CTRL && I_AHBS_HWDATA[0] && !I_AHBS_BUSY;
            O_AHBS_SRESET <= wr_en && dp_ofs == OFS_CTRL && I_AHBS_HWDATA[1];
            if (wr_en) begin
                case (dp_ofs)
                    OFS_CTRL:  irq_en          <= I_AHBS_HWDATA[2];
                    OFS_SRC:   O_AHBS_SRC_ADDR <= I_AHBS_HWDATA;
                    OFS_DST:   O_AHBS_DST_ADDR <= I_AHBS_HWDATA;
                    OFS_SIZE:  O_AHBS_SIZE     <= I_AHBS_HWDATA[2:0];
                    OFS_COUNT: O_AHBS_COUNT    <= I_AHBS_HWDATA[4:0];
                    default:   ;
                endcase
            end
            // A completion arriving alongside a clear must not be lost.
            if (I_AHBS_DONE)
                done <= 1'b1;
            else if (wr_en && I_AHBS_HWDATA[1] && (dp_ofs == OFS_STATUS || dp_ofs == OFS_CTRL))
                done <= 1'b0;
            O_AHBS_IRQ <= done & irq_en;
        end
    end

    always_comb begin
        O_AHBS_HRDATA = '0;
        if (dp_rd) begin
            case (dp_ofs)
                OFS_CTRL:   O_AHBS_HRDATA = {29'd0, irq_en, 2'b00};
                OFS_STATUS: O_AHBS_HRDATA = {30'd0, done, I_AHBS_BUSY};
                OFS_SRC:    O_AHBS_HRDATA = O_AHBS_SRC_ADDR;
                OFS_DST:    O_AHBS_HRDATA = O_AHBS_DST_ADDR;
                OFS_SIZE:   O_AHBS_HRDATA = {29'd0, O_AHBS_SIZE};
                OFS_COUNT:  O_AHBS_HRDATA = {27'd0, O_AHBS_COUNT};
                default:    O_AHBS_HRDATA = '0;
            endcase
        end
    end

endmodule
